load_store_unit: RTL and testbench

Load/store sequencer between the execute stage and the data memory. It accepts one memory request at a time over a valid/ready handshake and drives the data memory's address, write-enable and write-data inputs. It captures the memory's combinational read data and returns the result over a valid/ready response channel. It supports direct and indirect (pointer-in-memory) addressing, with optional pointer post-increment.

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load/store at a time between the execute
// stage and a combinational-read data memory. Supports direct addressing
// and indirect addressing through a pointer word in memory, with optional
// pointer post-increment written back after the access.
//
// Ports:
//   clk, nReset                 clock, synchronous active-low reset
//   ReqValid/ReqReady           request handshake
//   ReqWrite, ReqIndirect,
//   ReqPostInc, ReqAddr, ReqData request payload (sampled at accept edge)
//   RespValid/RespReady         response handshake
//   RespData                    load data or stored-data echo
//   MemAddr, MemWriteEnable,
//   MemWrData                   data memory drive
//   MemRdData                   data memory combinational read data
module load_store_unit #(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic                 ReqIndirect,
    input  logic                 ReqPostInc,
    input  logic [DataWidth-1:0] ReqAddr,
    input  logic [DataWidth-1:0] ReqData,
    output logic                 RespValid,
    input  logic                 RespReady,
    output logic [DataWidth-1:0] RespData,
    output logic [DataWidth-1:0] MemAddr,
    output logic                 MemWriteEnable,
    output logic [DataWidth-1:0] MemWrData,
    input  logic [DataWidth-1:0] MemRdData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_ACCESS,
        S_PTR_WB,
        S_RESP
    } state_t;

    state_t               state, state_next;
    logic                 lat_write, lat_write_next;
    logic                 lat_indirect, lat_indirect_next;
    logic                 lat_post_inc, lat_post_inc_next;
    logic [DataWidth-1:0] lat_addr, lat_addr_next;
    logic [DataWidth-1:0] lat_data, lat_data_next;
    logic [DataWidth-1:0] eff_addr, eff_addr_next;
    logic [DataWidth-1:0] resp_data, resp_data_next;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state        <= S_IDLE;
            lat_write    <= 1'b0;
            lat_indirect <= 1'b0;
            lat_post_inc <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            eff_addr     <= '0;
            resp_data    <= '0;
        end else begin
            state        <= state_next;
            lat_write    <= lat_write_next;
            lat_indirect <= lat_indirect_next;
            lat_post_inc <= lat_post_inc_next;
            lat_addr     <= lat_addr_next;
            lat_data     <= lat_data_next;
            eff_addr     <= eff_addr_next;
            resp_data    <= resp_data_next;
        end
    end

    // Next-state and memory/handshake output decode
    always_comb begin
        state_next        = state;
        lat_write_next    = lat_write;
        lat_indirect_next = lat_indirect;
        lat_post_inc_next = lat_post_inc;
        lat_addr_next     = lat_addr;
        lat_data_next     = lat_data;
        eff_addr_next     = eff_addr;
        resp_data_next    = resp_data;
        ReqReady          = 1'b0;
        RespValid         = 1'b0;
        MemAddr           = '0;
        MemWriteEnable    = 1'b0;
        MemWrData         = '0;

        case (state)
            S_IDLE: begin
                ReqReady = nReset;
                if (ReqValid && nReset) begin
                    lat_write_next    = ReqWrite;
                    lat_indirect_next = ReqIndirect;
                    lat_post_inc_next = ReqPostInc;
                    lat_addr_next     = ReqAddr;
                    lat_data_next     = ReqData;
                    if (ReqIndirect) begin
                        state_next = S_PTR;
                    end else begin
                        eff_addr_next = ReqAddr;
                        state_next    = S_ACCESS;
                    end
                end
            end

            // Fetch the pointer word; it becomes the effective address
            S_PTR: begin
                MemAddr       = lat_addr;
                eff_addr_next = MemRdData;
                state_next    = S_ACCESS;
            end

            S_ACCESS: begin
                MemAddr        = eff_addr;
                MemWriteEnable = lat_write;
                MemWrData      = lat_write ? lat_data : '0;
                resp_data_next = lat_write ? lat_data : MemRdData;
                state_next     = (lat_indirect && lat_post_inc) ? S_PTR_WB : S_RESP;
            end

            // Pointer write-back; wraps modulo 2^DataWidth and, if the pointer
            // aliases the effective address, overwrites the store just made
            S_PTR_WB: begin
                MemAddr        = lat_addr;
                MemWriteEnable = 1'b1;
                MemWrData      = DataWidth'(eff_addr + DataWidth'(1));
                state_next     = S_RESP;
            end

            S_RESP: begin
                RespValid = 1'b1;
                if (RespReady) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign RespData = resp_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed, table-driven bench for load_store_unit with
// a behavioural 256x8 data memory (combinational read, reads 0 while written).
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       nReset;
    logic       ReqValid, ReqReady, ReqWrite, ReqIndirect, ReqPostInc;
    logic [7:0] ReqAddr, ReqData;
    logic       RespValid, RespReady;
    logic [7:0] RespData;
    logic [7:0] MemAddr, MemWrData, MemRdData;
    logic       MemWriteEnable;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DataWidth(8)) dut (
        .clk            (clk),
        .nReset         (nReset),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .ReqWrite       (ReqWrite),
        .ReqIndirect    (ReqIndirect),
        .ReqPostInc     (ReqPostInc),
        .ReqAddr        (ReqAddr),
        .ReqData        (ReqData),
        .RespValid      (RespValid),
        .RespReady      (RespReady),
        .RespData       (RespData),
        .MemAddr        (MemAddr),
        .MemWriteEnable (MemWriteEnable),
        .MemWrData      (MemWrData),
        .MemRdData      (MemRdData)
    );

    // Data memory model
    logic [7:0] mem [256];
    logic       mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (MemWriteEnable) begin
            mem[MemAddr] <= MemWrData;
        end
    end

    assign MemRdData = MemWriteEnable ? 8'h00 : mem[MemAddr];

    typedef struct {
        string      name;
        logic       wr;
        logic       ind;
        logic       pinc;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] e_addr1;
        logic       e_we1;
        logic [7:0] e_wd1;
        logic [7:0] e_resp;
        int         e_lat;
    } vec_t;

    function automatic vec_t mk(input string name, input logic wr, input logic ind,
                                input logic pinc, input logic [7:0] addr, input logic [7:0] data,
                                input logic [7:0] e_addr1, input logic e_we1,
                                input logic [7:0] e_wd1, input logic [7:0] e_resp,
                                input int e_lat);
        vec_t v;
        v.name = name; v.wr = wr; v.ind = ind; v.pinc = pinc; v.addr = addr;
        v.data = data; v.e_addr1 = e_addr1; v.e_we1 = e_we1; v.e_wd1 = e_wd1;
        v.e_resp = e_resp; v.e_lat = e_lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One request: accept, cycle-1 memory drive, latency, optional response
    // stall of 'hold' cycles, handshake and return to idle.
    task automatic do_req(input vec_t v, input int hold);
        int lat;
        ReqValid    = 1'b1;
        ReqWrite    = v.wr;
        ReqIndirect = v.ind;
        ReqPostInc  = v.pinc;
        ReqAddr     = v.addr;
        ReqData     = v.data;
        RespReady   = 1'b0;
        #1;
        chk({v.name, "_req_ready"}, 32'(ReqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Garbage with ReqValid still high: must be ignored while busy
        ReqWrite    = 1'($urandom);
        ReqIndirect = 1'($urandom);
        ReqPostInc  = 1'($urandom);
        ReqAddr     = 8'($urandom);
        ReqData     = 8'($urandom);
        chk({v.name, "_c1_addr"}, 32'(MemAddr), 32'(v.e_addr1));
        chk({v.name, "_c1_we"}, 32'(MemWriteEnable), 32'(v.e_we1));
        chk({v.name, "_c1_wd"}, 32'(MemWrData), 32'(v.e_wd1));
        chk({v.name, "_c1_busy"}, 32'(ReqReady), 32'd0);
        lat = 1;
        while (!RespValid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_latency"}, 32'(lat), 32'(v.e_lat));
        chk({v.name, "_resp"}, 32'(RespData), 32'(v.e_resp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({v.name, "_hold_valid"}, 32'(RespValid), 32'd1);
            chk({v.name, "_hold_data"}, 32'(RespData), 32'(v.e_resp));
            chk({v.name, "_hold_ready"}, 32'(ReqReady), 32'd0);
            chk({v.name, "_hold_we"}, 32'(MemWriteEnable), 32'd0);
        end
        RespReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RespReady = 1'b0;
        ReqValid  = 1'b0;
        #1;
        chk({v.name, "_done_valid"}, 32'(RespValid), 32'd0);
        chk({v.name, "_done_ready"}, 32'(ReqReady), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        // Memory starts as mem[a]=a
        vecs.push_back(mk("ld_2a",     0, 0, 0, 8'h2A, 8'h00, 8'h2A, 0, 8'h00, 8'h2A, 2));
        vecs.push_back(mk("st_10",     1, 0, 0, 8'h10, 8'h5C, 8'h10, 1, 8'h5C, 8'h5C, 2));
        vecs.push_back(mk("ld_10",     0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 8'h00, 8'h5C, 2));
        vecs.push_back(mk("st_05",     1, 0, 0, 8'h05, 8'h80, 8'h05, 1, 8'h80, 8'h80, 2));
        vecs.push_back(mk("ipi_ld_05", 0, 1, 1, 8'h05, 8'h00, 8'h05, 0, 8'h00, 8'h80, 4));
        vecs.push_back(mk("ld_05",     0, 0, 0, 8'h05, 8'h00, 8'h05, 0, 8'h00, 8'h81, 2));
        vecs.push_back(mk("st_07",     1, 0, 0, 8'h07, 8'hFF, 8'h07, 1, 8'hFF, 8'hFF, 2));
        vecs.push_back(mk("ipi_st_07", 1, 1, 1, 8'h07, 8'h11, 8'h07, 0, 8'h00, 8'h11, 4));
        vecs.push_back(mk("ld_ff",     0, 0, 0, 8'hFF, 8'h00, 8'hFF, 0, 8'h00, 8'h11, 2));
        vecs.push_back(mk("ld_07",     0, 0, 0, 8'h07, 8'h00, 8'h07, 0, 8'h00, 8'h00, 2));
        vecs.push_back(mk("ind_st_05", 1, 1, 0, 8'h05, 8'h3C, 8'h05, 0, 8'h00, 8'h3C, 3));
        vecs.push_back(mk("ld_81",     0, 0, 0, 8'h81, 8'h00, 8'h81, 0, 8'h00, 8'h3C, 2));
        vecs.push_back(mk("ld_05b",    0, 0, 0, 8'h05, 8'h00, 8'h05, 0, 8'h00, 8'h81, 2));
        vecs.push_back(mk("ipi_st_20", 1, 1, 1, 8'h20, 8'h99, 8'h20, 0, 8'h00, 8'h99, 4));
        vecs.push_back(mk("ld_20",     0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 8'h00, 8'h21, 2));
        vecs.push_back(mk("st_30_pinc",1, 0, 1, 8'h30, 8'h44, 8'h30, 1, 8'h44, 8'h44, 2));
        vecs.push_back(mk("ld_31",     0, 0, 0, 8'h31, 8'h00, 8'h31, 0, 8'h00, 8'h31, 2));
        vecs.push_back(mk("ld_30",     0, 0, 0, 8'h30, 8'h00, 8'h30, 0, 8'h00, 8'h44, 2));
        vecs.push_back(mk("ind_ld_10", 0, 1, 0, 8'h10, 8'h00, 8'h10, 0, 8'h00, 8'h5C, 3));

        nReset = 1'b0; mem_init = 1'b1;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqIndirect = 1'b0; ReqPostInc = 1'b0;
        ReqAddr = 8'h00; ReqData = 8'h00; RespReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(ReqReady), 32'd0);
        chk("rst_resp_valid", 32'(RespValid), 32'd0);
        chk("rst_resp_data", 32'(RespData), 32'd0);
        chk("rst_mem_addr", 32'(MemAddr), 32'd0);
        chk("rst_mem_we", 32'(MemWriteEnable), 32'd0);
        chk("rst_mem_wd", 32'(MemWrData), 32'd0);
        mem_init = 1'b0;
        nReset   = 1'b1;
        #1;
        chk("rst_release_ready", 32'(ReqReady), 32'd1);
        @(negedge clk);

        foreach (vecs[i]) do_req(vecs[i], 0);

        // Response stall: mem[0x2A] is still 0x2A
        do_req(mk("hold_ld_2a", 0, 0, 0, 8'h2A, 8'h00, 8'h2A, 0, 8'h00, 8'h2A, 2), 5);

        // Reset during PTR of an indirect post-inc store through 0x05 (ptr 0x81)
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqIndirect = 1'b1; ReqPostInc = 1'b1;
        ReqAddr = 8'h05; ReqData = 8'h77;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        chk("abort_ptr_addr", 32'(MemAddr), 32'h05);
        nReset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_resp_valid", 32'(RespValid), 32'd0);
        chk("abort_we", 32'(MemWriteEnable), 32'd0);
        chk("abort_addr", 32'(MemAddr), 32'd0);
        chk("abort_ready_in_rst", 32'(ReqReady), 32'd0);
        nReset = 1'b1;
        #1;
        chk("abort_ready", 32'(ReqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_idle_we", 32'(MemWriteEnable), 32'd0);
        chk("abort_idle_valid", 32'(RespValid), 32'd0);
        do_req(mk("abort_ld_81", 0, 0, 0, 8'h81, 8'h00, 8'h81, 0, 8'h00, 8'h3C, 2), 0);
        do_req(mk("abort_ld_05", 0, 0, 0, 8'h05, 8'h00, 8'h05, 0, 8'h00, 8'h81, 2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
